// File: rtl/bus_request_arbiter_pkg.sv
// Shared types and default widths for the serial-bus request arbiter.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_COMPLETE  = 3'd4
  } arb_state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int DEF_NUM_REQ        = 2;
  localparam int DEF_SLAVE_LEN      = 2;
  localparam int DEF_ADDR_LEN       = 12;
  localparam int DEF_DATA_LEN       = 8;
  localparam int DEF_BURST_LEN      = 12;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // Index width that stays at least one bit wide.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_request_arbiter_if.sv
// Requester-side and event-handler-side signals of the bus request arbiter.
import bus_arb_pkg::*;

interface bus_request_arbiter_if #(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int SLAVE_LEN = DEF_SLAVE_LEN,
  parameter int ADDR_LEN  = DEF_ADDR_LEN,
  parameter int DATA_LEN  = DEF_DATA_LEN,
  parameter int BURST_LEN = DEF_BURST_LEN
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_write;
  logic [NUM_REQ*SLAVE_LEN-1:0] req_slave;
  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr;
  logic [NUM_REQ*DATA_LEN-1:0]  req_data;
  logic [NUM_REQ*BURST_LEN-1:0] req_burst;
  logic [NUM_REQ-1:0]           req_ack;
  logic [NUM_REQ-1:0]           req_done;
  logic [NUM_REQ-1:0]           req_err;
  logic [NUM_REQ-1:0]           rd_valid;
  logic [DATA_LEN-1:0]          rd_data;
  logic                         eh_write;
  logic                         eh_read;
  logic [SLAVE_LEN-1:0]         eh_slave;
  logic [ADDR_LEN-1:0]          eh_addr;
  logic [DATA_LEN-1:0]          eh_data;
  logic [BURST_LEN-1:0]         eh_burst;
  logic                         eh_busy;
  logic                         rx_new;
  logic [DATA_LEN-1:0]          rx_data;

  modport slave (
    input  req_valid, req_write, req_slave, req_addr, req_data, req_burst,
    output req_ack, req_done, req_err, rd_valid, rd_data,
    output eh_write, eh_read, eh_slave, eh_addr, eh_data, eh_burst,
    input  eh_busy, rx_new, rx_data
  );

  modport master (
    output req_valid, req_write, req_slave, req_addr, req_data, req_burst,
    input  req_ack, req_done, req_err, rd_valid, rd_data,
    input  eh_write, eh_read, eh_slave, eh_addr, eh_data, eh_burst,
    output eh_busy, rx_new, rx_data
  );
endinterface

// File: rtl/bus_request_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
import bus_arb_pkg::*;

module rr_priority_pick #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);
  logic [IW:0] cand;

  // Scan NUM_REQ candidates from rr_ptr; explicit modulo keeps non-power-of-two counts in range.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(off);
      cand = (cand >= (IW+1)'(NUM_REQ)) ? cand - (IW+1)'(NUM_REQ) : cand;
      if (!any && req[cand[IW-1:0]]) begin
        any   = 1'b1;
        idx   = cand[IW-1:0];
        grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << cand[IW-1:0];
      end else begin
        any   = any;
      end
    end
  end
endmodule

// File: rtl/bus_request_arbiter.sv
// Round-robin arbiter sharing one serial-bus event handler among NUM_REQ requesters.
// Optional watchdog enabled by defining BUS_ARB_WATCHDOG_EN.
import bus_arb_pkg::*;

module bus_request_arbiter #(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int SLAVE_LEN      = DEF_SLAVE_LEN,
  parameter int ADDR_LEN       = DEF_ADDR_LEN,
  parameter int DATA_LEN       = DEF_DATA_LEN,
  parameter int BURST_LEN      = DEF_BURST_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                   clk,
  input logic                   reset,
  bus_request_arbiter_if.slave  bus
);
  localparam int IW = idx_width(NUM_REQ);

  arb_state_t           state_r, state_next_s;
  logic [IW-1:0]        rr_ptr_r, owner_r, pick_idx_s;
  logic                 op_r, pick_any_s, grant_en_s, fwd_s, timeout_hit_s;
  logic [NUM_REQ-1:0]   pick_grant_s, owner_onehot_s, err_set_s;
  logic [NUM_REQ-1:0]   ack_r, done_r, err_r, rd_valid_r;
  logic [DATA_LEN-1:0]  rd_data_r, eh_data_r;
  logic                 eh_write_r, eh_read_r;
  logic [SLAVE_LEN-1:0] eh_slave_r;
  logic [ADDR_LEN-1:0]  eh_addr_r;
  logic [BURST_LEN-1:0] eh_burst_r;

  rr_priority_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_r),
    .grant  (pick_grant_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  assign owner_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;

`ifdef BUS_ARB_WATCHDOG_EN
  localparam int WD_W = idx_width(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_cnt_r;
  logic            timeout_r;

  assign timeout_hit_s = ((state_r == ST_WAIT_BUSY) || (state_r == ST_WAIT_DONE)) &&
                         (wd_cnt_r == WD_W'(TIMEOUT_CYCLES-1));
  assign err_set_s     = ((state_r == ST_COMPLETE) && timeout_r) ? owner_onehot_s : '0;

  // Watchdog counter restarts as the strobe goes out and runs while waiting on the handler.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_r  <= '0;
      timeout_r <= 1'b0;
    end else if (state_r == ST_ISSUE) begin
      wd_cnt_r  <= '0;
      timeout_r <= 1'b0;
    end else if ((state_r == ST_WAIT_BUSY) || (state_r == ST_WAIT_DONE)) begin
      wd_cnt_r  <= wd_cnt_r + WD_W'(1);
      timeout_r <= timeout_hit_s;
    end else begin
      wd_cnt_r  <= wd_cnt_r;
      timeout_r <= timeout_r;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign err_set_s     = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state logic plus grant and read-forward qualifiers.
  always_comb begin
    state_next_s = state_r;
    grant_en_s   = 1'b0;
    fwd_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s && !bus.eh_busy) begin
          grant_en_s   = 1'b1;
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_next_s = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        fwd_s = (op_r == OP_READ) && bus.rx_new;
        if (timeout_hit_s)    state_next_s = ST_COMPLETE;
        else if (bus.eh_busy) state_next_s = ST_WAIT_DONE;
        else                  state_next_s = ST_WAIT_BUSY;
      end
      ST_WAIT_DONE: begin
        fwd_s = (op_r == OP_READ) && bus.rx_new;
        if (timeout_hit_s)     state_next_s = ST_COMPLETE;
        else if (!bus.eh_busy) state_next_s = ST_COMPLETE;
        else                   state_next_s = ST_WAIT_DONE;
      end
      ST_COMPLETE: state_next_s = ST_IDLE;
      default:     state_next_s = ST_IDLE;
    endcase
  end

  // Registered outputs, latched command and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_r      <= '0;
      done_r     <= '0;
      err_r      <= '0;
      rd_valid_r <= '0;
      rd_data_r  <= '0;
      eh_write_r <= 1'b0;
      eh_read_r  <= 1'b0;
      eh_slave_r <= '0;
      eh_addr_r  <= '0;
      eh_data_r  <= '0;
      eh_burst_r <= '0;
      owner_r    <= '0;
      op_r       <= OP_READ;
      rr_ptr_r   <= '0;
    end else begin
      ack_r      <= grant_en_s ? pick_grant_s : '0;
      eh_write_r <= (state_r == ST_ISSUE) && (op_r == OP_WRITE);
      eh_read_r  <= (state_r == ST_ISSUE) && (op_r == OP_READ);
      rd_valid_r <= fwd_s ? owner_onehot_s : '0;
      rd_data_r  <= fwd_s ? bus.rx_data : rd_data_r;
      done_r     <= (state_r == ST_COMPLETE) ? owner_onehot_s : '0;
      err_r      <= err_set_s;
      if (grant_en_s) begin
        owner_r    <= pick_idx_s;
        op_r       <= bus.req_write[pick_idx_s];
        eh_slave_r <= bus.req_slave[pick_idx_s*SLAVE_LEN +: SLAVE_LEN];
        eh_addr_r  <= bus.req_addr[pick_idx_s*ADDR_LEN +: ADDR_LEN];
        eh_data_r  <= bus.req_data[pick_idx_s*DATA_LEN +: DATA_LEN];
        eh_burst_r <= bus.req_burst[pick_idx_s*BURST_LEN +: BURST_LEN];
      end else begin
        owner_r    <= owner_r;
        op_r       <= op_r;
        eh_slave_r <= eh_slave_r;
        eh_addr_r  <= eh_addr_r;
        eh_data_r  <= eh_data_r;
        eh_burst_r <= eh_burst_r;
      end
      if (state_r == ST_COMPLETE)
        rr_ptr_r <= (owner_r == IW'(NUM_REQ-1)) ? '0 : owner_r + IW'(1);
      else
        rr_ptr_r <= rr_ptr_r;
    end
  end

  assign bus.req_ack  = ack_r;
  assign bus.req_done = done_r;
  assign bus.req_err  = err_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_data  = rd_data_r;
  assign bus.eh_write = eh_write_r;
  assign bus.eh_read  = eh_read_r;
  assign bus.eh_slave = eh_slave_r;
  assign bus.eh_addr  = eh_addr_r;
  assign bus.eh_data  = eh_data_r;
  assign bus.eh_burst = eh_burst_r;
endmodule

// File: tb/tb_bus_request_arbiter.sv
// Directed self-checking bench for bus_request_arbiter (two requesters).
`timescale 1ns/1ps
module tb_bus_request_arbiter;
  localparam int NUM_REQ = 2;
`ifdef BUS_ARB_WATCHDOG_EN
  localparam int TIMEOUT_CYCLES = 16;
`else
  localparam int TIMEOUT_CYCLES = 4096;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bus_request_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  bus_request_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    logic [7:0] rbytes [3];
    logic [1:0] order [4];
    int         k;
    rbytes = '{8'h11, 8'h22, 8'h33};
    order  = '{2'b01, 2'b10, 2'b01, 2'b10};

    bus.req_valid = '0; bus.req_write = '0; bus.req_slave = '0; bus.req_addr = '0;
    bus.req_data = '0; bus.req_burst = '0; bus.eh_busy = 1'b0; bus.rx_new = 1'b0; bus.rx_data = '0;

    // Reset state
    tick(); tick();
    check("rst_ack", 32'(bus.req_ack), 32'd0);
    check("rst_done", 32'(bus.req_done), 32'd0);
    check("rst_ehw", 32'({bus.eh_write, bus.eh_read}), 32'd0);
    check("rst_addr", 32'(bus.eh_addr), 32'd0);
    reset = 1'b0;

    // Single write from requester 0
    bus.req_valid = 2'b01; bus.req_write = 2'b01;
    bus.req_slave = {2'd0, 2'd2}; bus.req_addr = {12'h000, 12'h01A};
    bus.req_data = {8'h00, 8'h5C}; bus.req_burst = {12'd0, 12'd1};
    tick();
    check("w_ack", 32'(bus.req_ack), 32'd1);
    check("w_nostrobe", 32'(bus.eh_write), 32'd0);
    bus.req_valid = 2'b00;
    bus.req_data = {8'h00, 8'hFF};
    tick();
    check("w_ack_pulse", 32'(bus.req_ack), 32'd0);
    check("w_strobe", 32'({bus.eh_write, bus.eh_read}), 32'h2);
    check("w_slave", 32'(bus.eh_slave), 32'd2);
    check("w_addr", 32'(bus.eh_addr), 32'h01A);
    check("w_data", 32'(bus.eh_data), 32'h5C);
    check("w_burst", 32'(bus.eh_burst), 32'd1);
    bus.eh_busy = 1'b1;
    tick();
    check("w_strobe_end", 32'(bus.eh_write), 32'd0);
    repeat (9) tick();
    check("w_no_early_done", 32'(bus.req_done), 32'd0);
    bus.eh_busy = 1'b0;
    tick();
    check("w_done_p1", 32'(bus.req_done), 32'd0);
    tick();
    check("w_done", 32'(bus.req_done), 32'd1);
    check("w_err", 32'(bus.req_err), 32'd0);
    check("w_no_rd", 32'(bus.rd_valid), 32'd0);
    tick();
    check("w_done_pulse", 32'(bus.req_done), 32'd0);

    // Read burst of three bytes from requester 1
    bus.req_valid = 2'b10; bus.req_write = 2'b00;
    bus.req_slave = {2'd1, 2'd0}; bus.req_addr = {12'h3C4, 12'h000}; bus.req_burst = {12'd3, 12'd0};
    tick();
    check("r_ack", 32'(bus.req_ack), 32'h2);
    bus.req_valid = 2'b00;
    tick();
    check("r_strobe", 32'({bus.eh_write, bus.eh_read}), 32'h1);
    check("r_slave", 32'(bus.eh_slave), 32'd1);
    check("r_addr", 32'(bus.eh_addr), 32'h3C4);
    check("r_burst", 32'(bus.eh_burst), 32'd3);
    bus.eh_busy = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) begin
      bus.rx_new = 1'b1; bus.rx_data = rbytes[b];
      tick();
      check("r_rdv", 32'(bus.rd_valid), 32'h2);
      check("r_rdd", 32'(bus.rd_data), 32'(rbytes[b]));
      bus.rx_new = 1'b0;
      tick();
      check("r_rdv_low", 32'(bus.rd_valid), 32'd0);
    end
    bus.eh_busy = 1'b0;
    tick();
    check("r_done_p1", 32'(bus.req_done), 32'd0);
    tick();
    check("r_done", 32'(bus.req_done), 32'h2);

    // Fairness: both requesters held valid across four transactions
    bus.req_valid = 2'b11; bus.req_write = 2'b11;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("f_ack", 32'(bus.req_ack), 32'(order[t]));
      tick();
      check("f_strobe", 32'(bus.eh_write), 32'd1);
      bus.eh_busy = 1'b1;
      tick();
      bus.eh_busy = 1'b0;
      tick();
      tick();
      check("f_done", 32'(bus.req_done), 32'(order[t]));
    end
    bus.req_valid = 2'b00;

    // Last read byte coincident with busy falling
    bus.req_valid = 2'b01; bus.req_write = 2'b00;
    tick();
    check("s_ack", 32'(bus.req_ack), 32'd1);
    bus.req_valid = 2'b00;
    tick();
    check("s_strobe", 32'(bus.eh_read), 32'd1);
    bus.eh_busy = 1'b1;
    tick();
    bus.rx_new = 1'b1; bus.rx_data = 8'hA7; bus.eh_busy = 1'b0;
    tick();
    bus.rx_new = 1'b0;
    check("s_rdv", 32'(bus.rd_valid), 32'd1);
    check("s_rdd", 32'(bus.rd_data), 32'hA7);
    check("s_done_early", 32'(bus.req_done), 32'd0);
    tick();
    check("s_rdv_low", 32'(bus.rd_valid), 32'd0);
    check("s_done", 32'(bus.req_done), 32'd1);

    // Reset in WAIT_DONE abandons requester 1 and restarts the pointer at 0
    bus.req_valid = 2'b10; bus.req_write = 2'b00;
    tick();
    check("x_ack", 32'(bus.req_ack), 32'h2);
    bus.req_valid = 2'b00;
    tick();
    bus.eh_busy = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("x_rst_outs", 32'({bus.req_ack, bus.req_done, bus.rd_valid, bus.eh_write, bus.eh_read}), 32'd0);
    check("x_rst_addr", 32'(bus.eh_addr), 32'd0);
    check("x_rst_slave", 32'(bus.eh_slave), 32'd0);
    reset = 1'b0; bus.eh_busy = 1'b0;
    tick();
    check("x_no_done1", 32'(bus.req_done), 32'd0);
    bus.req_valid = 2'b11; bus.req_write = 2'b11;
    tick();
    check("x_fresh_ack", 32'(bus.req_ack), 32'd1);
    bus.req_valid = 2'b00;
    tick();
    check("x_strobe", 32'(bus.eh_write), 32'd1);
    bus.eh_busy = 1'b1;

`ifdef BUS_ARB_WATCHDOG_EN
    // Handler stuck busy: watchdog completes with an error pulse
    k = 0;
    while (bus.req_done == 2'b00 && k < 64) begin
      tick();
      k++;
    end
    check("wd_done", 32'(bus.req_done), 32'd1);
    check("wd_err", 32'(bus.req_err), 32'd1);
    bus.req_valid = 2'b01;
    repeat (3) begin
      tick();
      check("wd_no_ack", 32'(bus.req_ack), 32'd0);
    end
    bus.eh_busy = 1'b0;
    tick();
    check("wd_ack_recover", 32'(bus.req_ack), 32'd1);
    bus.req_valid = 2'b00;
`else
    k = 0;
    tick();
    bus.eh_busy = 1'b0;
    tick();
    tick();
    check("n_done", 32'(bus.req_done), 32'd1);
    check("n_err", 32'(bus.req_err), 32'd0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish before 200000ns");
    $fatal(1, "timeout");
  end
endmodule
